// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage MIPS core
//   in : clk, reset (sync, active-low), ID source regs/uses, EX load/dest info,
//        ex_redirect, mem_access, dmem_ready
//   out: pc_en, if2id_en, if2id_flush, id2ex_hazard, id2ex_en, ex2mem_en,
//        stall_cycles, flush_count (saturating perf counters)
module hazard_ctrl #(
  parameter int LOADUSE_CYCLES = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_memtoreg,
  input  logic             ex_regwriteen,
  input  logic [4:0]       ex_writereg,
  input  logic             ex_redirect,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if2id_en,
  output logic             if2id_flush,
  output logic             id2ex_hazard,
  output logic             id2ex_en,
  output logic             ex2mem_en,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  typedef enum logic [1:0] {RUN, LDUSE, MEMWAIT} state_t;
  state_t state_q, state_d, saved_q, saved_d, eff;
  logic [3:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic hit, memstall, redirect, bubble;
  always_comb begin
    hit = ex_memtoreg & ex_regwriteen & (ex_writereg != 5'd0) &
          ((id_uses_rs & (id_rs == ex_writereg)) | (id_uses_rt & (id_rt == ex_writereg)));
    memstall = mem_access & ~dmem_ready;
    // MEMWAIT behaves as the state it interrupted once the access completes
    eff = (state_q == MEMWAIT) ? saved_q : state_q;
    redirect = ~memstall & ex_redirect;
    bubble = ~memstall & ~ex_redirect & ((eff == LDUSE) | hit);
    pc_en = ~reset | ~(memstall | bubble);
    if2id_en = ~reset | ~(memstall | bubble);
    id2ex_en = ~reset | ~memstall;
    ex2mem_en = ~reset | ~memstall;
    if2id_flush = reset & redirect;
    id2ex_hazard = reset & (redirect | bubble);
    state_d = memstall ? MEMWAIT :
              redirect ? RUN :
              (eff == LDUSE) ? ((cnt_q == 4'd1) ? RUN : LDUSE) :
              (hit && LOADUSE_CYCLES > 1) ? LDUSE : RUN;
    cnt_d = memstall ? cnt_q :
            redirect ? 4'd0 :
            (eff == LDUSE) ? cnt_q - 4'd1 :
            (hit && LOADUSE_CYCLES > 1) ? 4'(LOADUSE_CYCLES - 1) : 4'd0;
    saved_d = memstall ? eff : saved_q;
    stall_d = (~pc_en & ~&stall_q) ? stall_q + 1'b1 : stall_q;
    flush_d = (if2id_flush & ~&flush_q) ? flush_q + 1'b1 : flush_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      saved_q <= RUN;
      cnt_q <= 4'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q <= cnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign stall_cycles = stall_q;
  assign flush_count = flush_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  logic clk = 0, reset = 0;
  logic [4:0] id_rs, id_rt, ex_writereg;
  logic id_uses_rs, id_uses_rt, ex_memtoreg, ex_regwriteen, ex_redirect, mem_access, dmem_ready;
  logic pc1, if1, fl1, hz1, ie1, em1;
  logic pc3, if3, fl3, hz3, ie3, em3;
  logic pc4, if4, fl4, hz4, ie4, em4;
  logic [15:0] st1, fc1, st3, fc3;
  logic [3:0] st4, fc4;
  int n_assert = 0, n_fail = 0;
  always #5 clk = ~clk;
  hazard_ctrl u1 (.clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_memtoreg(ex_memtoreg), .ex_regwriteen(ex_regwriteen),
    .ex_writereg(ex_writereg), .ex_redirect(ex_redirect), .mem_access(mem_access),
    .dmem_ready(dmem_ready), .pc_en(pc1), .if2id_en(if1), .if2id_flush(fl1), .id2ex_hazard(hz1),
    .id2ex_en(ie1), .ex2mem_en(em1), .stall_cycles(st1), .flush_count(fc1));
  hazard_ctrl #(.LOADUSE_CYCLES(3)) u3 (.clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_memtoreg(ex_memtoreg),
    .ex_regwriteen(ex_regwriteen), .ex_writereg(ex_writereg), .ex_redirect(ex_redirect),
    .mem_access(mem_access), .dmem_ready(dmem_ready), .pc_en(pc3), .if2id_en(if3),
    .if2id_flush(fl3), .id2ex_hazard(hz3), .id2ex_en(ie3), .ex2mem_en(em3),
    .stall_cycles(st3), .flush_count(fc3));
  hazard_ctrl #(.CNT_W(4)) u4 (.clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_memtoreg(ex_memtoreg),
    .ex_regwriteen(ex_regwriteen), .ex_writereg(ex_writereg), .ex_redirect(ex_redirect),
    .mem_access(mem_access), .dmem_ready(dmem_ready), .pc_en(pc4), .if2id_en(if4),
    .if2id_flush(fl4), .id2ex_hazard(hz4), .id2ex_en(ie4), .ex2mem_en(em4),
    .stall_cycles(st4), .flush_count(fc4));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; ex_memtoreg = 0; ex_regwriteen = 0;
    ex_writereg = 0; ex_redirect = 0; mem_access = 0; dmem_ready = 1;
  endtask
  task automatic hit8();
    idle();
    ex_memtoreg = 1; ex_regwriteen = 1; ex_writereg = 8; id_rs = 8; id_uses_rs = 1;
  endtask
  task automatic do_reset();
    idle();
    reset = 0;
    @(negedge clk);
    reset = 1;
  endtask
  initial begin
    idle();
    ex_redirect = 1; mem_access = 1; dmem_ready = 0;
    repeat (3) begin
      @(negedge clk);
      #1 chk("rst_pc_en", pc3, 1);
      chk("rst_flush", fl3, 0);
      chk("rst_hazard", hz3, 0);
      chk("rst_ex2mem", em3, 1);
    end
    reset = 1; idle();
    #1 chk("rst_stall", st3, 0);
    chk("rst_flushcnt", fc3, 0);
    chk("rst_if2id_en", if1, 1);
    // load-use, one bubble
    @(negedge clk); hit8();
    #1 chk("lu1_pc_en", pc1, 0);
    chk("lu1_if2id_en", if1, 0);
    chk("lu1_hazard", hz1, 1);
    chk("lu1_id2ex_en", ie1, 1);
    @(negedge clk); idle();
    #1 chk("lu1_after_pc", pc1, 1);
    chk("lu1_after_hz", hz1, 0);
    chk("lu1_stall", st1, 1);
    // load-use, three bubbles
    do_reset(); hit8();
    #1 chk("lu3_b1", pc3, 0);
    @(negedge clk); idle();
    #1 chk("lu3_b2", pc3, 0);
    chk("lu3_b2_hz", hz3, 1);
    @(negedge clk);
    #1 chk("lu3_b3", pc3, 0);
    @(negedge clk);
    #1 chk("lu3_run", pc3, 1);
    chk("lu3_run_hz", hz3, 0);
    chk("lu3_stall", st3, 3);
    // hit against $0 is ignored
    do_reset(); idle();
    ex_memtoreg = 1; ex_regwriteen = 1; ex_writereg = 0; id_rt = 0; id_uses_rt = 1;
    #1 chk("r0_pc_en", pc3, 1);
    chk("r0_hazard", hz3, 0);
    @(negedge clk); idle();
    #1 chk("r0_stall", st3, 0);
    // redirect in second bubble
    do_reset(); hit8();
    @(negedge clk); idle(); ex_redirect = 1;
    #1 chk("rd_flush", fl3, 1);
    chk("rd_pc_en", pc3, 1);
    chk("rd_if2id_en", if3, 1);
    chk("rd_hazard", hz3, 1);
    @(negedge clk); idle();
    #1 chk("rd_run", pc3, 1);
    chk("rd_noflush", fl3, 0);
    chk("rd_flushcnt", fc3, 1);
    chk("rd_stall", st3, 1);
    // memory wait in LDUSE with counter 2
    do_reset(); hit8();
    @(negedge clk); idle(); mem_access = 1; dmem_ready = 0;
    repeat (4) begin
      #1 chk("mw_pc_en", pc3, 0);
      chk("mw_id2ex_en", ie3, 0);
      chk("mw_ex2mem_en", em3, 0);
      chk("mw_hazard", hz3, 0);
      @(negedge clk);
    end
    dmem_ready = 1;
    #1 chk("mw_b2_pc", pc3, 0);
    chk("mw_b2_hz", hz3, 1);
    chk("mw_b2_em", em3, 1);
    @(negedge clk); idle();
    #1 chk("mw_b3_pc", pc3, 0);
    chk("mw_b3_hz", hz3, 1);
    @(negedge clk);
    #1 chk("mw_run", pc3, 1);
    chk("mw_stall", st3, 7);
    // flush counter saturation
    do_reset(); idle(); ex_redirect = 1;
    repeat (20) @(negedge clk);
    idle();
    #1 chk("sat_flush4", fc4, 15);
    chk("sat_flush16", fc1, 20);
    chk("sat_stall4", st4, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
